// File: rtl/divide_16bit_if.sv
// divide_16bit_if
// Groups the divider's request/response signals into one bundle.
//   master modport : drives start, sgn, A, B; observes results and status
//   slave modport  : the divider itself; observes the request, drives
//                    Quot, Rem, busy, done, Ovfl, DivZero
interface divide_16bit_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sgn;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Quot;
   logic [WIDTH-1:0] Rem;
   logic             busy;
   logic             done;
   logic             Ovfl;
   logic             DivZero;

   modport master (
      output start, sgn, A, B,
      input  Quot, Rem, busy, done, Ovfl, DivZero
   );

   modport slave (
      input  start, sgn, A, B,
      output Quot, Rem, busy, done, Ovfl, DivZero
   );
endinterface

// File: rtl/divide_16bit.sv
// divide_16bit
// Multi-cycle restoring divider: one conditional subtract per clock,
// signed or unsigned operands, quotient truncated toward zero and
// remainder carrying the sign of the dividend.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, discards any operation in flight
//   bus  : slave side of divide_16bit_if (start/sgn/A/B in,
//          Quot/Rem/busy/done/Ovfl/DivZero out, all outputs registered)
// Timing: accepting edge E0, 16 CALC edges, FIN edge E17 writes results
// and raises done for one cycle.
module divide_16bit #(
   parameter int WIDTH = 16
) (
   input logic          clk,
   input logic          rst,
   divide_16bit_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   prem_q, prem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] a_raw_q, a_raw_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             ov_q, ov_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             ovfl_q, ovfl_d;
   logic             divzero_q, divzero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Operand magnitudes, the trial subtract and the final sign fixup.
   // The magnitude of the most negative value is still exact as an
   // unsigned WIDTH-bit number, and the partial remainder carries one
   // extra bit so the shifted value never truncates. The trial is one
   // bit wider again so its MSB is a clean borrow flag.
   always_comb begin
      a_mag   = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
      b_mag   = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
      shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      trial   = {1'b0, shifted} - {2'b00, dvs_q};
      q_fix   = qneg_q ? -dvd_q : dvd_q;
      r_fix   = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
   end

   // Next-state logic for the IDLE -> CALC -> FIN sequence. The dividend
   // register doubles as the quotient register: each CALC step shifts one
   // dividend bit out of the top and one quotient bit in at the bottom.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      prem_d    = prem_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      a_raw_d   = a_raw_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      dz_d      = dz_q;
      ov_d      = ov_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      ovfl_d    = ovfl_q;
      divzero_d = divzero_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_d   = a_mag;
               dvs_d   = b_mag;
               a_raw_d = bus.A;
               qneg_d  = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & bus.sgn;
               rneg_d  = bus.A[WIDTH-1] & bus.sgn;
               dz_d    = (bus.B == '0);
               ov_d    = bus.sgn && (bus.A == MIN_NEG) && (bus.B == '1);
               prem_d  = '0;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
            prem_d  = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            // A zero divisor overrides whatever the iterations produced.
            if (dz_q) begin
               quot_d = '1;
               rem_d  = a_raw_q;
            end else begin
               quot_d = q_fix;
               rem_d  = r_fix;
            end
            ovfl_d    = ov_q;
            divzero_d = dz_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All state and registered outputs; reset abandons any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         prem_q    <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         a_raw_q   <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         ov_q      <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         ovfl_q    <= 1'b0;
         divzero_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         prem_q    <= prem_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         a_raw_q   <= a_raw_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         dz_q      <= dz_d;
         ov_q      <= ov_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         ovfl_q    <= ovfl_d;
         divzero_q <= divzero_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.Quot    = quot_q;
   assign bus.Rem     = rem_q;
   assign bus.Ovfl    = ovfl_q;
   assign bus.DivZero = divzero_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_divide_16bit.sv
// tb_divide_16bit
// Directed bench for divide_16bit: reset values, unsigned and signed
// division, boundary operands, divide by zero, start while busy, start in
// the done cycle, and reset in the middle of an operation. Inputs change
// and outputs are sampled on the falling edge.
module tb_divide_16bit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   divide_16bit_if #(.WIDTH(16)) bus ();

   divide_16bit #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Waits on falling edges until done rises, giving up after 40 edges.
   // cnt counts rising edges passed since the accepting edge.
   task automatic wait_done(input int start_cnt, output int cnt);
      cnt = start_cnt;
      while (bus.done !== 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   // Presents one request for a single cycle; returns just after the
   // accepting edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.sgn   = s;
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = 16'h5A5A;
      bus.B     = 16'hA5A5;
   endtask

   // Outputs while reset is held.
   task automatic test_reset;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sgn   = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.Ovfl, bus.DivZero} !== 4'b0000 ||
          bus.Quot !== 16'h0000 || bus.Rem !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL reset_state: busy=%b done=%b ovfl=%b dz=%b quot=%h rem=%h, want all 0",
                  bus.busy, bus.done, bus.Ovfl, bus.DivZero, bus.Quot, bus.Rem);
      end
      rst = 1'b0;
   endtask

   // One complete division with latency, result and flag checks.
   task automatic test_divide(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic s, input logic [15:0] eq, input logic [15:0] er,
                              input logic eov, input logic edz);
      int cnt;
      issue(a, b, s);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s busy_after_accept: got %b want 1", name, bus.busy);
      end
      wait_done(0, cnt);
      n_checks++;
      if (cnt != 17) begin
         n_fail++;
         $display("[TB] FAIL %s latency: got %0d want 17", name, cnt);
      end
      n_checks++;
      if (bus.Quot !== eq || bus.Rem !== er) begin
         n_fail++;
         $display("[TB] FAIL %s result: got quot=%h rem=%h want quot=%h rem=%h",
                  name, bus.Quot, bus.Rem, eq, er);
      end
      n_checks++;
      if (bus.Ovfl !== eov || bus.DivZero !== edz || bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s flags: got ovfl=%b dz=%b busy=%b want ovfl=%b dz=%b busy=0",
                  name, bus.Ovfl, bus.DivZero, bus.busy, eov, edz);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.Quot !== eq) begin
         n_fail++;
         $display("[TB] FAIL %s done_pulse_hold: got done=%b quot=%h want done=0 quot=%h",
                  name, bus.done, bus.Quot, eq);
      end
   endtask

   // A second start during busy cycle 5 must be ignored.
   task automatic test_start_while_busy;
      int cnt;
      issue(16'd100, 16'd7, 1'b0);
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 16'd50;
      bus.B     = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(5, cnt);
      n_checks++;
      if (cnt != 17 || bus.Quot !== 16'd14 || bus.Rem !== 16'd2) begin
         n_fail++;
         $display("[TB] FAIL busy_restart: got lat=%0d quot=%0d rem=%0d want lat=17 quot=14 rem=2",
                  cnt, bus.Quot, bus.Rem);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL busy_restart_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
   endtask

   // start asserted during the done cycle launches a second operation.
   task automatic test_back_to_back;
      int cnt;
      issue(16'd100, 16'd7, 1'b0);
      wait_done(0, cnt);
      n_checks++;
      if (cnt != 17 || bus.Quot !== 16'd14) begin
         n_fail++;
         $display("[TB] FAIL b2b_first: got lat=%0d quot=%0d want lat=17 quot=14", cnt, bus.Quot);
      end
      bus.start = 1'b1;
      bus.A     = 16'd1000;
      bus.B     = 16'd10;
      bus.sgn   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy);
      end
      wait_done(0, cnt);
      n_checks++;
      if (cnt != 17 || bus.Quot !== 16'd100 || bus.Rem !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL b2b_second: got lat=%0d quot=%0d rem=%0d want lat=17 quot=100 rem=0",
                  cnt, bus.Quot, bus.Rem);
      end
      @(negedge clk);
   endtask

   // Asynchronous reset between edges in the middle of CALC.
   task automatic test_reset_mid_op;
      bit seen_done;
      issue(16'd100, 16'd7, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.Ovfl, bus.DivZero} !== 4'b0000 ||
          bus.Quot !== 16'h0000 || bus.Rem !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_clear: busy=%b done=%b ovfl=%b dz=%b quot=%h rem=%h, want all 0",
                  bus.busy, bus.done, bus.Ovfl, bus.DivZero, bus.Quot, bus.Rem);
      end
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
      end
      n_checks++;
      if (seen_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset_no_done: got activity=%b want 0", seen_done);
      end
      test_divide("after_reset", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0);
   endtask

   // Test sequence.
   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_divide("unsigned_100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, 1'b0);
      test_divide("signed_m7_2", 16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
      test_divide("signed_7_m2", 16'd7, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
      test_divide("signed_m7_m2", 16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0);
      test_divide("unsigned_max_1", 16'hFFFF, 16'd1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
      test_divide("signed_ovfl", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0);
      test_divide("unsigned_8000_ffff", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0);
      test_divide("signed_m32768_7", 16'h8000, 16'd7, 1'b1, 16'hEDB7, 16'hFFFF, 1'b0, 1'b0);
      test_divide("divzero_unsigned", 16'd1234, 16'd0, 1'b0, 16'hFFFF, 16'd1234, 1'b0, 1'b1);
      test_divide("divzero_signed", 16'd1234, 16'd0, 1'b1, 16'hFFFF, 16'd1234, 1'b0, 1'b1);
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
